layer_three: RTL and testbench

- Final classifier stage of the BNN pipeline; reads the 4x7x7 binary feature map produced by the layer-two stage.
- Fully-connected XNOR-popcount layer with 10 output classes, followed by a sequential argmax.
- Emits the predicted digit plus its score and raises a sticky done flag.
- Runs only while the top-level FSM is in its layer-3 state.

---
 rtl/layer_three.sv | 93 +++++++++
 tb/tb_layer_three.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_three.sv
// BNN classifier stage: 196-bit XNOR-popcount over 10 classes with running argmax, 40 active cycles to done.
// Stalls (holds all state) whenever state != S_LAYER_3; frozen after done until reset.
module layer_three #(
    parameter int N_IN = 196,
    parameter int N_CLASS = 10,
    parameter int CHUNK = 49,
    parameter logic [2:0] S_LAYER_3 = 3'b100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                state,
    input  logic [N_IN-1:0]           features,
    input  logic [N_IN*N_CLASS-1:0]   weights,
    output logic [3:0]                digit,
    output logic [7:0]                best_score,
    output logic                      done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } fsm_t;

    fsm_t        r_fsm;
    logic [3:0]  r_cls;
    logic [1:0]  r_chunk;
    logic [7:0]  r_acc;
    logic [7:0]  r_best;
    logic [3:0]  r_digit;
    logic        r_done;

    logic [7:0]       w_fbase;
    logic [10:0]      w_wbase;
    logic [CHUNK-1:0] w_match;
    logic [5:0]       w_pop;
    logic [7:0]       w_total;
    logic             w_active;
    logic             w_better;

    // One filter plane per cycle: chunk selects the plane, cls selects the weight row.
    assign w_fbase  = 8'(r_chunk) * 8'(CHUNK);
    assign w_wbase  = 11'(r_cls) * 11'(N_IN) + 11'(w_fbase);
    assign w_match  = ~(features[w_fbase +: CHUNK] ^ weights[w_wbase +: CHUNK]);
    assign w_total  = r_acc + 8'(w_pop);
    assign w_active = (state == S_LAYER_3) && (r_fsm != ST_DONE);
    // Strict compare keeps the lowest class index on ties; class 0 always seeds the argmax.
    assign w_better = (r_cls == 4'd0) || (w_total > r_best);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_pop = w_pop + 6'(w_match[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_cls   <= '0;
            r_chunk <= '0;
            r_acc   <= '0;
            r_best  <= '0;
            r_digit <= '0;
            r_done  <= 1'b0;
        end else if (w_active) begin
            r_fsm <= ST_ACCUM;
            if (r_chunk != 2'd3) begin
                r_acc   <= w_total;
                r_chunk <= r_chunk + 2'd1;
            end else begin
                if (w_better) begin
                    r_best  <= w_total;
                    r_digit <= r_cls;
                end
                r_acc   <= '0;
                r_chunk <= '0;
                if (r_cls == 4'(N_CLASS - 1)) begin
                    r_cls  <= '0;
                    r_done <= 1'b1;
                    r_fsm  <= ST_DONE;
                end else begin
                    r_cls <= r_cls + 4'd1;
                end
            end
        end
    end

    assign digit      = r_digit;
    assign best_score = r_best;
    assign done       = r_done;

endmodule

// File: tb/tb_layer_three.sv
module tb_layer_three;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    state;
    logic [195:0]  features;
    logic [1959:0] weights;
    logic [3:0]    digit;
    logic [7:0]    best_score;
    logic          done;

    always #5 clk = ~clk;

    layer_three dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .features   (features),
        .weights    (weights),
        .digit      (digit),
        .best_score (best_score),
        .done       (done)
    );

    localparam logic [2:0] S3 = 3'b100;

    typedef struct {
        logic [3:0] d;
        logic [7:0] s;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] score(input int c);
        logic [195:0] w;
        int s;
        w = weights[c*196 +: 196];
        s = 0;
        for (int i = 0; i < 196; i++) if (features[i] == w[i]) s++;
        return 8'(s);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.d = 4'd0;
        e.s = score(0);
        for (int c = 1; c < 10; c++) begin
            if (score(c) > e.s) begin
                e.s = score(c);
                e.d = 4'(c);
            end
        end
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty at done", tag);
            return;
        end
        e = sb.pop_front();
        last_e = e;
        chk({tag, "_digit"}, 32'(digit), 32'(e.d));
        chk({tag, "_score"}, 32'(best_score), 32'(e.s));
    endtask

    task automatic do_reset();
        state = 3'b000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Counts clocks with state active until done is seen, bounded by budget.
    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        state = S3;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", tag, budget);
        end
    endtask

    task automatic rand_features();
        logic [223:0] tmp;
        for (int i = 0; i < 7; i++) tmp[i*32 +: 32] = $urandom;
        features = tmp[195:0];
    endtask

    task automatic setup_cls7();
        rand_features();
        for (int c = 0; c < 10; c++) weights[c*196 +: 196] = (c == 7) ? features : ~features;
    endtask

    initial begin
        rst_n    = 1'b0;
        state    = 3'b000;
        features = '0;
        weights  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_digit", 32'(digit), 0);
        chk("rst_score", 32'(best_score), 0);
        chk("rst_done", 32'(done), 0);

        // all-zero operands: every class scores 196, class 0 wins
        push_exp();
        state = S3;
        repeat (39) tick();
        chk("zero_done_at_39", 32'(done), 0);
        tick();
        chk("zero_done_at_40", 32'(done), 1);
        pop_chk("zero");
        chk("zero_score_const", 32'(best_score), 196);

        // class 7 is an exact match, others all mismatch
        setup_cls7();
        do_reset();
        push_exp();
        state = S3;
        repeat (4) tick();
        chk("c7_digit_after_cls0", 32'(digit), 0);
        chk("c7_score_after_cls0", 32'(best_score), 0);
        wait_done("c7", 100, cyc);
        chk("c7_latency", 32'(cyc + 4), 40);
        pop_chk("c7");
        chk("c7_digit_const", 32'(digit), 7);

        // tie between classes 3 and 5 at 150 matches, rest at 100
        rand_features();
        for (int c = 0; c < 10; c++) begin
            logic [195:0] w;
            int k;
            w = features;
            k = (c == 3 || c == 5) ? 46 : 96;
            for (int j = 0; j < k; j++) w[j] = ~w[j];
            weights[c*196 +: 196] = w;
        end
        do_reset();
        push_exp();
        wait_done("tie", 100, cyc);
        chk("tie_latency", 32'(cyc), 40);
        pop_chk("tie");
        chk("tie_digit_const", 32'(digit), 3);
        chk("tie_score_const", 32'(best_score), 150);

        // pause for 5 cycles after active edge 17
        setup_cls7();
        do_reset();
        push_exp();
        state = S3;
        repeat (17) tick();
        state = 3'b011;
        repeat (5) tick();
        chk("pause_done_held", 32'(done), 0);
        wait_done("pause", 100, cyc);
        chk("pause_total_clocks", 32'(17 + 5 + cyc), 45);
        pop_chk("pause");

        // reset mid-run, then a full run with random weights
        rand_features();
        for (int i = 0; i < 1960 / 20; i++) weights[i*20 +: 20] = 20'($urandom);
        do_reset();
        state = S3;
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_digit", 32'(digit), 0);
        chk("midrst_score", 32'(best_score), 0);
        chk("midrst_done", 32'(done), 0);
        push_exp();
        wait_done("midrst", 100, cyc);
        chk("midrst_latency", 32'(cyc), 40);
        pop_chk("midrst");

        // after done, changing inputs must not disturb the result
        features = ~features;
        state = S3;
        repeat (10) tick();
        chk("hold_done", 32'(done), 1);
        chk("hold_digit", 32'(digit), 32'(last_e.d));
        chk("hold_score", 32'(best_score), 32'(last_e.s));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
